// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one RV64 LD/SD at a time through a single-handshake data bus.
module mem_access_ctrl #(
  parameter int XLEN        = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] wdata,
  output logic            dreq_valid,
  output logic            dreq_write,
  output logic [XLEN-1:0] dreq_addr,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic            write_q, write_d, err_q, err_d;
  logic [XLEN-1:0] ea;
  logic            mem_op, bad;
  assign ea     = base + imm;
  assign mem_op = is_load | is_store;
  // Illegal encodings and misaligned memory ops complete with an error and never touch the bus.
  assign bad    = (is_load & is_store) | (mem_op & ALIGN_CHECK & (ea[2:0] != 3'd0));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid && !flush) begin
        addr_d  = ea;
        wdata_d = wdata;
        write_d = is_store;
        data_d  = '0;
        err_d   = bad;
        state_d = (mem_op && !bad) ? REQ : RESP;
      end
      REQ: if (dresp_data_ok) begin
        data_d  = write_q ? '0 : dresp_data;
        state_d = flush ? IDLE : RESP;
      end else if (flush) state_d = DRAIN;
      RESP:    if (flush || out_ready) state_d = IDLE;
      DRAIN:   if (dresp_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign dreq_valid  = (state_q == REQ) || (state_q == DRAIN);
  assign dreq_write  = dreq_valid & write_q;
  assign dreq_addr   = addr_q;
  assign dreq_strobe = dreq_write ? 8'hFF : 8'h00;
  assign dreq_data   = wdata_q;
  assign out_valid   = state_q == RESP;
  assign out_data    = out_valid ? data_q : '0;
  assign out_err     = out_valid & err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl handshakes, errors, flush and reset.
module tb_mem_access_ctrl;
  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic        is_load = 1'b0, is_store = 1'b0, dresp_data_ok = 1'b0, out_ready = 1'b0;
  logic [63:0] base = '0, imm = '0, wdata = '0, dresp_data = '0;
  logic        in_ready, dreq_valid, dreq_write, out_valid, out_err;
  logic [63:0] dreq_addr, dreq_data, out_data;
  logic [7:0]  dreq_strobe;
  int          errors = 0, checks = 0;
  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .base(base), .imm(imm), .wdata(wdata),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic ld, input logic st, input logic [63:0] b, input logic [63:0] i,
                       input logic [63:0] w);
    in_valid = 1'b1; is_load = ld; is_store = st; base = b; imm = i; wdata = w;
    step();
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_dreq_addr", dreq_addr, 0);
    step();
    reset = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    // 1: load with negative offset, response three cycles after accept
    issue(1, 0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    chk("t1_dreq_valid", dreq_valid, 1);
    chk("t1_addr", dreq_addr, 64'hFF8);
    chk("t1_strobe", dreq_strobe, 8'h00);
    chk("t1_write", dreq_write, 0);
    chk("t1_in_ready", in_ready, 0);
    step();
    chk("t1_hold_addr", dreq_addr, 64'hFF8);
    step();
    dresp_data_ok = 1'b1; dresp_data = 64'hDEADBEEF;
    chk("t1_out_valid_early", out_valid, 0);
    step();
    dresp_data_ok = 1'b0; dresp_data = 64'h0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 64'hDEADBEEF);
    chk("t1_out_err", out_err, 0);
    chk("t1_dreq_drop", dreq_valid, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_idle", in_ready, 1);
    chk("t1_out_clear", out_valid, 0);
    // 2: store, data_ok in first request cycle
    issue(0, 1, 64'h2000, 64'h10, 64'h55);
    dresp_data_ok = 1'b1; dresp_data = 64'h1111;
    chk("t2_dreq_valid", dreq_valid, 1);
    chk("t2_write", dreq_write, 1);
    chk("t2_addr", dreq_addr, 64'h2010);
    chk("t2_strobe", dreq_strobe, 8'hFF);
    chk("t2_data", dreq_data, 64'h55);
    step();
    dresp_data_ok = 1'b0;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_idle", in_ready, 1);
    // 3: misaligned load errors without bus traffic
    issue(1, 0, 64'h1003, 64'h0, 0);
    chk("t3_no_req", dreq_valid, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_err", out_err, 1);
    chk("t3_out_data", out_data, 0);
    out_ready = 1'b1;
    step();
    // illegal load+store and no-op
    issue(1, 1, 64'h3000, 64'h0, 0);
    chk("ill_no_req", dreq_valid, 0);
    chk("ill_err", out_err, 1);
    step();
    issue(0, 0, 64'h3001, 64'h0, 0);
    chk("nop_no_req", dreq_valid, 0);
    chk("nop_valid", out_valid, 1);
    chk("nop_err", out_err, 0);
    step();
    out_ready = 1'b0;
    // address wrap
    issue(1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 0);
    chk("wrap_addr", dreq_addr, 64'h8);
    chk("wrap_req", dreq_valid, 1);
    dresp_data_ok = 1'b1; dresp_data = 64'h77;
    step();
    dresp_data_ok = 1'b0;
    chk("wrap_data", out_data, 64'h77);
    // flush in RESP drops the result
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fresp_out_valid", out_valid, 0);
    chk("fresp_in_ready", in_ready, 1);
    // 4: flush in REQ drains the bus
    issue(1, 0, 64'h4000, 64'h8, 0);
    step();
    flush = 1'b1;
    step();
    chk("t4_drain_n3", dreq_valid, 1);
    step();
    flush = 1'b0;
    chk("t4_drain_n4", dreq_valid, 1);
    chk("t4_no_out_n4", out_valid, 0);
    step();
    dresp_data_ok = 1'b1; dresp_data = 64'hBAD;
    chk("t4_drain_n5", dreq_valid, 1);
    step();
    dresp_data_ok = 1'b0;
    chk("t4_in_ready_n6", in_ready, 1);
    chk("t4_no_out_n6", out_valid, 0);
    chk("t4_dreq_n6", dreq_valid, 0);
    // flush with data_ok in REQ returns straight to IDLE
    issue(1, 0, 64'h5000, 64'h0, 0);
    flush = 1'b1; dresp_data_ok = 1'b1;
    step();
    flush = 1'b0; dresp_data_ok = 1'b0;
    chk("fok_in_ready", in_ready, 1);
    chk("fok_out_valid", out_valid, 0);
    // flush in IDLE suppresses accept
    in_valid = 1'b1; is_load = 1'b1; base = 64'h6000; flush = 1'b1;
    step();
    in_valid = 1'b0; is_load = 1'b0; flush = 1'b0;
    chk("fidle_no_req", dreq_valid, 0);
    chk("fidle_in_ready", in_ready, 1);
    // stray data_ok in IDLE is ignored
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    chk("stray_ok_out", out_valid, 0);
    // 5: backpressure holds the result
    issue(1, 0, 64'h7000, 64'h0, 0);
    dresp_data_ok = 1'b1; dresp_data = 64'h1234_5678_9ABC_DEF0;
    step();
    dresp_data_ok = 1'b0; dresp_data = 64'h0;
    for (int k = 0; k < 4; k++) begin
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_data", out_data, 64'h1234_5678_9ABC_DEF0);
      chk("t5_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_released", in_ready, 1);
    chk("t5_out_clear", out_valid, 0);
    // 6: asynchronous reset in REQ
    issue(1, 0, 64'h8000, 64'h0, 0);
    chk("t6_in_req", dreq_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_dreq", dreq_valid, 0);
    chk("t6_async_out", out_valid, 0);
    step();
    reset = 1'b0;
    step();
    chk("t6_in_ready", in_ready, 1);
    for (int k = 0; k < 2; k++) begin
      issue(1, 0, 64'h9000, 64'h8 * k, 0);
      chk("t6_b2b_addr", dreq_addr, 64'h9000 + 64'h8 * k);
      dresp_data_ok = 1'b1; dresp_data = 64'hA0 + k;
      step();
      dresp_data_ok = 1'b0;
      chk("t6_b2b_valid", out_valid, 1);
      chk("t6_b2b_data", out_data, 64'hA0 + k);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t6_b2b_idle", in_ready, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
